// File: rtl/wtr_pkg.sv
// Shared definitions for the write-target burst decoder: register codes,
// default geometry and the controller state encoding.
package wtr_pkg;

    // Default geometry of the writable register bank
    localparam int WTR_NUM_REGS_DEF = 14;
    localparam int WTR_SEL_W_DEF    = 5;

    // Register select codes (code 0 means "no write")
    localparam logic [4:0] WTR_NONE = 5'd0;
    localparam logic [4:0] WTR_N    = 5'd1;
    localparam logic [4:0] WTR_M    = 5'd2;
    localparam logic [4:0] WTR_P    = 5'd3;
    localparam logic [4:0] WTR_ROW  = 5'd4;
    localparam logic [4:0] WTR_COL  = 5'd5;
    localparam logic [4:0] WTR_CURR = 5'd6;
    localparam logic [4:0] WTR_SUM  = 5'd7;
    localparam logic [4:0] WTR_AVAL = 5'd8;
    localparam logic [4:0] WTR_STA  = 5'd9;
    localparam logic [4:0] WTR_STB  = 5'd10;
    localparam logic [4:0] WTR_STC  = 5'd11;
    localparam logic [4:0] WTR_A    = 5'd12;
    localparam logic [4:0] WTR_B    = 5'd13;
    localparam logic [4:0] WTR_AC   = 5'd14;

    // Controller states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wtr_state_e;

endpackage : wtr_pkg

// File: rtl/wtr_onehot_enc.sv
// Combinational select-code to one-hot encoder. Code i drives bit i-1;
// code 0 and codes above NUM_REGS produce an all-zero vector.
module wtr_onehot_enc
    import wtr_pkg::*;
#(
    parameter int NUM_REGS = WTR_NUM_REGS_DEF,
    parameter int SEL_W    = WTR_SEL_W_DEF
) (
    input  logic [SEL_W-1:0]    code_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    // Decode each bit independently so out-of-range codes match nothing
    always_comb begin
        onehot_o = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot_o[i] = (code_i == SEL_W'(i + 1));
        end
    end

endmodule : wtr_onehot_enc

// File: rtl/wtr_burst_decoder.sv
// Registered write-target decoder with burst mode. Turns a select code and
// enable into a one-hot register-bank write strobe, optionally stepping
// through consecutive registers one per cycle, and reports done, clip,
// select errors and dropped requests to the control unit.
module wtr_burst_decoder
    import wtr_pkg::*;
#(
    parameter int NUM_REGS = WTR_NUM_REGS_DEF,
    parameter int SEL_W    = WTR_SEL_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    WTR_sel,
    input  logic                WTR_en,
    input  logic [SEL_W-1:0]    burst_len,
    output logic [NUM_REGS-1:0] wtr_onehot,
    output logic                busy,
    output logic                done,
    output logic                sel_err,
    output logic                clip,
    output logic                req_drop
);

    localparam logic [SEL_W-1:0] LAST_CODE   = SEL_W'(NUM_REGS);
    localparam logic [SEL_W:0]   LAST_CODE_W = (SEL_W + 1)'(NUM_REGS);
    localparam logic [SEL_W-1:0] ONE         = SEL_W'(1);
    localparam logic [SEL_W-1:0] ZERO        = {SEL_W{1'b0}};

    wtr_state_e           state_q, state_d;
    logic [SEL_W-1:0]     cur_q, cur_d;
    logic [SEL_W-1:0]     rem_q, rem_d;
    logic                 clip_pend_q, clip_pend_d;

    logic [NUM_REGS-1:0]  onehot_q, onehot_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sel_err_q, sel_err_d;
    logic                 clip_q, clip_d;
    logic                 drop_q, drop_d;

    logic [SEL_W-1:0]     enc_code_s;
    logic [NUM_REGS-1:0]  enc_onehot_s;
    logic                 sel_valid_s;
    logic [SEL_W:0]       sel_sum_s;

    // While bursting the strobe follows the internal cursor, otherwise the request
    assign enc_code_s  = (state_q == ST_BURST) ? cur_q : WTR_sel;
    assign sel_valid_s = (WTR_sel != ZERO) && (WTR_sel <= LAST_CODE);
    // Widened so a large burst length cannot wrap and hide a clip
    assign sel_sum_s   = {1'b0, WTR_sel} + {1'b0, burst_len};

    wtr_onehot_enc #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_enc (
        .code_i   (enc_code_s),
        .onehot_o (enc_onehot_s)
    );

    // Next-state, burst counters and registered-output values
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        clip_pend_d = clip_pend_q;
        onehot_d    = {NUM_REGS{1'b0}};
        done_d      = 1'b0;
        sel_err_d   = 1'b0;
        clip_d      = 1'b0;
        drop_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (WTR_en) begin
                    if (sel_valid_s) begin
                        onehot_d = enc_onehot_s;
                        if (burst_len == ZERO) begin
                            done_d = 1'b1;
                        end else if (WTR_sel == LAST_CODE) begin
                            // Nothing follows the last register: truncate at once
                            done_d = 1'b1;
                            clip_d = 1'b1;
                        end else begin
                            cur_d       = WTR_sel + ONE;
                            rem_d       = burst_len - ONE;
                            clip_pend_d = (sel_sum_s > LAST_CODE_W);
                            state_d     = ST_BURST;
                        end
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else begin
                    onehot_d = {NUM_REGS{1'b0}};
                end
            end
            ST_BURST: begin
                onehot_d = enc_onehot_s;
                drop_d   = WTR_en;
                if ((rem_q == ZERO) || (cur_q == LAST_CODE)) begin
                    done_d  = 1'b1;
                    clip_d  = clip_pend_q;
                    state_d = ST_IDLE;
                end else begin
                    cur_d = cur_q + ONE;
                    rem_d = rem_q - ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_BURST);
    end

    // State, counters and output flags with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= ZERO;
            rem_q       <= ZERO;
            clip_pend_q <= 1'b0;
            onehot_q    <= {NUM_REGS{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_err_q   <= 1'b0;
            clip_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            clip_pend_q <= clip_pend_d;
            onehot_q    <= onehot_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sel_err_q   <= sel_err_d;
            clip_q      <= clip_d;
            drop_q      <= drop_d;
        end
    end

    assign wtr_onehot = onehot_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sel_err    = sel_err_q;
    assign clip       = clip_q;
    assign req_drop   = drop_q;

endmodule : wtr_burst_decoder

// File: tb/tb_wtr_burst_decoder.sv
// Directed bench for wtr_burst_decoder: each cycle's expected outputs are
// queued when the stimulus is applied and compared after the clock edge.
module tb_wtr_burst_decoder;

    localparam int NR = 14;
    localparam int SW = 5;

    logic          clk;
    logic          rst;
    logic [SW-1:0] WTR_sel;
    logic          WTR_en;
    logic [SW-1:0] burst_len;
    logic [NR-1:0] wtr_onehot;
    logic          busy;
    logic          done;
    logic          sel_err;
    logic          clip;
    logic          req_drop;

    // {onehot, busy, done, sel_err, clip, req_drop}
    logic [NR+4:0] exp_q[$];
    int            checks;
    int            errors;

    wtr_burst_decoder #(
        .NUM_REGS (NR),
        .SEL_W    (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .WTR_sel    (WTR_sel),
        .WTR_en     (WTR_en),
        .burst_len  (burst_len),
        .wtr_onehot (wtr_onehot),
        .busy       (busy),
        .done       (done),
        .sel_err    (sel_err),
        .clip       (clip),
        .req_drop   (req_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic cyc(input logic r, input logic en, input int sel, input int len,
                       input logic [NR-1:0] e_oh, input logic e_busy, input logic e_done,
                       input logic e_err, input logic e_clip, input logic e_drop,
                       input string tag);
        logic [NR+4:0] obs;
        logic [NR+4:0] exp_v;
        rst       = r;
        WTR_en    = en;
        WTR_sel   = SW'(sel);
        burst_len = SW'(len);
        exp_q.push_back({e_oh, e_busy, e_done, e_err, e_clip, e_drop});
        @(posedge clk);
        #1;
        obs   = {wtr_onehot, busy, done, sel_err, clip, req_drop};
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (onehot,busy,done,err,clip,drop)",
                   tag, obs, exp_v);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        WTR_en    = 1'b0;
        WTR_sel   = '0;
        burst_len = '0;

        // Reset state
        cyc(1'b1, 1'b0, 0, 0, 14'h0000, 0, 0, 0, 0, 0, "reset0");
        cyc(1'b1, 1'b1, 3, 0, 14'h0000, 0, 0, 0, 0, 0, "reset_req_ignored");
        cyc(1'b0, 1'b0, 0, 0, 14'h0000, 0, 0, 0, 0, 0, "idle_after_reset");

        // Single write
        cyc(1'b0, 1'b1, 3, 0, 14'h0004, 0, 1, 0, 0, 0, "single_sel3");

        // Back-to-back singles
        cyc(1'b0, 1'b1, 1, 0, 14'h0001, 0, 1, 0, 0, 0, "b2b_sel1");
        cyc(1'b0, 1'b1, 2, 0, 14'h0002, 0, 1, 0, 0, 0, "b2b_sel2");
        cyc(1'b0, 1'b1, 14, 0, 14'h2000, 0, 1, 0, 0, 0, "b2b_sel14");
        cyc(1'b0, 1'b0, 0, 0, 14'h0000, 0, 0, 0, 0, 0, "idle_gap");

        // Burst 11 + 2 more
        cyc(1'b0, 1'b1, 11, 2, 14'h0400, 1, 0, 0, 0, 0, "burst11_s0");
        cyc(1'b0, 1'b0, 0, 0, 14'h0800, 1, 0, 0, 0, 0, "burst11_s1");
        cyc(1'b0, 1'b0, 0, 0, 14'h1000, 0, 1, 0, 0, 0, "burst11_last");

        // Burst ending exactly on the last register: no clip
        cyc(1'b0, 1'b1, 12, 2, 14'h0800, 1, 0, 0, 0, 0, "exact12_s0");
        cyc(1'b0, 1'b0, 0, 0, 14'h1000, 1, 0, 0, 0, 0, "exact12_s1");
        cyc(1'b0, 1'b0, 0, 0, 14'h2000, 0, 1, 0, 0, 0, "exact12_last");

        // Clipped burst, followed without a bubble by the sel=14 special case
        cyc(1'b0, 1'b1, 12, 5, 14'h0800, 1, 0, 0, 0, 0, "clip12_s0");
        cyc(1'b0, 1'b0, 0, 0, 14'h1000, 1, 0, 0, 0, 0, "clip12_s1");
        cyc(1'b0, 1'b0, 0, 0, 14'h2000, 0, 1, 0, 1, 0, "clip12_last");
        cyc(1'b0, 1'b1, 14, 3, 14'h2000, 0, 1, 0, 1, 0, "clip14_single");
        cyc(1'b0, 1'b0, 0, 0, 14'h0000, 0, 0, 0, 0, 0, "idle_after_clip");

        // Select errors
        cyc(1'b0, 1'b1, 0, 0, 14'h0000, 0, 0, 1, 0, 0, "err_sel0");
        cyc(1'b0, 1'b1, 15, 2, 14'h0000, 0, 0, 1, 0, 0, "err_sel15");
        cyc(1'b0, 1'b1, 31, 0, 14'h0000, 0, 0, 1, 0, 0, "err_sel31");

        // Request during a burst is dropped; burst continues unchanged
        cyc(1'b0, 1'b1, 4, 2, 14'h0008, 1, 0, 0, 0, 0, "drop_s0");
        cyc(1'b0, 1'b1, 9, 0, 14'h0010, 1, 0, 0, 0, 1, "drop_s1");
        cyc(1'b0, 1'b0, 0, 0, 14'h0020, 0, 1, 0, 0, 0, "drop_last");

        // Reset in the middle of a burst
        cyc(1'b0, 1'b1, 2, 6, 14'h0002, 1, 0, 0, 0, 0, "rstmid_s0");
        cyc(1'b0, 1'b0, 0, 0, 14'h0004, 1, 0, 0, 0, 0, "rstmid_s1");
        cyc(1'b0, 1'b0, 0, 0, 14'h0008, 1, 0, 0, 0, 0, "rstmid_s2");
        cyc(1'b1, 1'b0, 0, 0, 14'h0000, 0, 0, 0, 0, 0, "rstmid_cleared");
        cyc(1'b0, 1'b0, 0, 0, 14'h0000, 0, 0, 0, 0, 0, "rstmid_no_done");
        cyc(1'b0, 1'b1, 5, 0, 14'h0010, 0, 1, 0, 0, 0, "after_rst_sel5");
        cyc(1'b0, 1'b0, 0, 0, 14'h0000, 0, 0, 0, 0, 0, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_wtr_burst_decoder
